// File: rtl/gsim_sched.sv
// Round-robin front end that time-shares one Gauss-Seidel solver among NUM_REQ clients.
// Forwards the granted client's b words into the solver and returns the tagged x burst.
//
// state   | meaning
// S_IDLE  | no job; arbitrate pending requests from rr_ptr upward
// S_LOAD  | forward granted client's b words until NUM_VAR accepted
// S_WAIT  | solver iterating; wait for its SEND-phase flag
// S_DRAIN | return NUM_VAR x words to the owning client, then release grant
module gsim_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int NUM_VAR = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    cl_req,
    output logic [NUM_REQ-1:0]    cl_gnt,
    input  logic [NUM_REQ-1:0]    cl_b_valid,
    input  logic [NUM_REQ*16-1:0] cl_b_data,
    output logic                  sv_in_en,
    output logic [15:0]           sv_b_in,
    input  logic                  sv_out_valid,
    input  logic [31:0]           sv_x_out,
    output logic                  res_valid,
    output logic [31:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_last,
    output logic                  busy
);

    localparam int CNT_W = $clog2(NUM_VAR) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN} state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gid;
    logic [CNT_W-1:0] ld_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             x_dly;

    logic [15:0]          b_word [NUM_REQ];
    logic [2*NUM_REQ-1:0] req_rot;
    logic                 pick_any;
    logic [ID_W-1:0]      pick_id;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign b_word[k] = cl_b_data[16*k +: 16];
    end

    // Doubling the request vector lets a plain shift implement the wrap-around search.
    assign req_rot = {cl_req, cl_req} >> rr_ptr;

    always_comb begin
        pick_any = 1'b0;
        pick_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_any && req_rot[i]) begin
                pick_any = 1'b1;
                pick_id  = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            gid       <= '0;
            ld_cnt    <= '0;
            rd_cnt    <= '0;
            x_dly     <= 1'b0;
            cl_gnt    <= '0;
            sv_in_en  <= 1'b0;
            sv_b_in   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_last  <= 1'b0;
        end else begin
            sv_in_en  <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    x_dly <= 1'b0;
                    if (pick_any) begin
                        cl_gnt <= NUM_REQ'(1) << pick_id;
                        gid    <= pick_id;
                        ld_cnt <= '0;
                        rd_cnt <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    x_dly    <= 1'b0;
                    sv_in_en <= cl_b_valid[gid];
                    sv_b_in  <= b_word[gid];
                    if (cl_b_valid[gid]) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        if (ld_cnt == CNT_W'(NUM_VAR - 1)) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (sv_out_valid) begin
                        x_dly <= 1'b1;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    x_dly <= sv_out_valid;
                    if (x_dly) begin
                        res_valid <= 1'b1;
                        res_data  <= sv_x_out;
                        res_id    <= gid;
                        res_last  <= (rd_cnt == CNT_W'(NUM_VAR - 1));
                        rd_cnt    <= rd_cnt + 1'b1;
                        if (rd_cnt == CNT_W'(NUM_VAR - 1)) begin
                            cl_gnt <= '0;
                            x_dly  <= 1'b0;
                            rr_ptr <= (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_sched.sv
// Directed bench for gsim_sched: a table of jobs run through a behavioural solver,
// plus hand sequences for spurious solver flags and a mid-drain reset.
module tb_gsim_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  cl_req;
    logic [3:0]  cl_gnt;
    logic [3:0]  cl_b_valid;
    logic [63:0] cl_b_data;
    logic        sv_in_en;
    logic [15:0] sv_b_in;
    logic        sv_out_valid;
    logic [31:0] sv_x_out;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_id;
    logic        res_last;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int dead_seen = 0;
    int ovl    = 0;
    logic spur;

    gsim_sched #(.NUM_REQ(4), .ID_W(2), .NUM_VAR(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cl_req(cl_req), .cl_gnt(cl_gnt),
        .cl_b_valid(cl_b_valid), .cl_b_data(cl_b_data),
        .sv_in_en(sv_in_en), .sv_b_in(sv_b_in),
        .sv_out_valid(sv_out_valid), .sv_x_out(sv_x_out),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_last(res_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Solver model: collect 16 b words, iterate for a few cycles, then send x_k = {b_k, 16'h0}.
    logic        sol_ov;
    logic [31:0] sol_x;
    logic [15:0] bbuf [16];
    int          s_ph, s_cnt, s_dly, p_idx;
    logic        pend;

    assign sv_out_valid = sol_ov | spur;
    assign sv_x_out     = sol_x;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_ph <= 0; s_cnt <= 0; s_dly <= 0; p_idx <= 0;
            pend <= 1'b0; sol_ov <= 1'b0; sol_x <= '0;
        end else begin
            pend   <= 1'b0;
            sol_ov <= 1'b0;
            sol_x  <= pend ? {bbuf[p_idx], 16'h0000} : 32'h0;
            case (s_ph)
                0: if (sv_in_en) begin
                    bbuf[s_cnt] <= sv_b_in;
                    if (s_cnt == 15) begin s_cnt <= 0; s_ph <= 1; s_dly <= 4; end
                    else s_cnt <= s_cnt + 1;
                end
                1: if (s_dly == 0) s_ph <= 2; else s_dly <= s_dly - 1;
                default: begin
                    sol_ov <= 1'b1;
                    pend   <= 1'b1;
                    p_idx  <= s_cnt;
                    if (s_cnt == 15) begin s_cnt <= 0; s_ph <= 0; end
                    else s_cnt <= s_cnt + 1;
                end
            endcase
        end
    end

    // Monitor samples shortly after each rising edge, well clear of the negedge driver.
    logic [15:0] sv_q [$];
    int          sc_q [$];
    logic [34:0] rq   [$];
    int          rc_q [$];

    always @(posedge clk) begin
        #2;
        if (reset_n) begin
            if (sv_in_en) begin sv_q.push_back(sv_b_in); sc_q.push_back(cyc); end
            if (res_valid) begin rq.push_back({res_last, res_id, res_data}); rc_q.push_back(cyc); end
            if (sv_b_in == 16'hDEAD) dead_seen++;
            if (!$onehot0(cl_gnt)) ovl++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        int          client;
        int          exp_id;
        logic [15:0] base;
        bit          hold;
        bit          gapped;
        bit          extra;
        bit          iso;
        bit          spur_ld;
        int          abort_at;
    } job_t;

    // Called at a negedge with the DUT idle; returns at the negedge where the job has ended.
    task automatic run_job(input job_t j);
        int t0;
        int n;
        sv_q.delete(); sc_q.delete(); rq.delete(); rc_q.delete();
        chk("idle_before_req", busy, 1'b0);
        cl_req = j.req;
        @(negedge clk);
        chk("grant", cl_gnt, 4'b0001 << j.exp_id);
        chk("busy_granted", busy, 1'b1);
        if (!j.hold) cl_req = '0;
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            cl_b_valid[j.client] = 1'b1;
            cl_b_data[j.client*16 +: 16] = 16'(j.base + k);
            if (j.iso) begin
                cl_b_valid[3] = (k % 2 == 1);
                cl_b_data[48 +: 16] = 16'hDEAD;
            end
            if (j.spur_ld && k == 5) spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
            if (j.gapped) begin
                cl_b_valid[j.client] = 1'b0;
                @(negedge clk);
            end
        end
        if (j.extra) begin
            cl_b_valid[j.client] = 1'b1;
            cl_b_data[j.client*16 +: 16] = 16'(j.base + 16);
            @(negedge clk);
        end
        cl_b_valid = '0;
        cl_b_data  = '0;
        n = 0;
        while (n < 400 && rq.size() < 16 && !(j.abort_at != 0 && rq.size() >= j.abort_at)) begin
            @(negedge clk);
            n++;
        end
        if (j.abort_at != 0) begin
            chk("abort_reached", rq.size(), j.abort_at);
        end else begin
            chk("sv_in_count", sv_q.size(), 16);
            for (int k = 0; k < 16 && k < sv_q.size(); k++) begin
                chk("sv_in_data", sv_q[k], 16'(j.base + k));
                chk("sv_in_latency", sc_q[k], t0 + 1 + (j.gapped ? 2*k : k));
            end
            chk("res_count", rq.size(), 16);
            for (int k = 0; k < 16 && k < rq.size(); k++) begin
                chk("res_data", rq[k][31:0], {16'(j.base + k + 0), 16'h0000});
                chk("res_id", rq[k][33:32], j.exp_id);
                chk("res_last", rq[k][34], (k == 15));
                chk("res_consecutive", rc_q[k], rc_q[0] + k);
            end
            chk("gnt_released", cl_gnt, 4'b0000);
        end
    endtask

    job_t jobs [9];
    job_t jr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req      cl id base     hold gap extra iso spur abort
        jobs[0] = '{4'b1111, 0, 0, 16'h0010, 1, 0, 0, 0, 0, 0};
        jobs[1] = '{4'b1111, 1, 1, 16'h0020, 1, 0, 0, 0, 0, 0};
        jobs[2] = '{4'b1111, 2, 2, 16'h0030, 1, 0, 0, 0, 0, 0};
        jobs[3] = '{4'b1111, 3, 3, 16'h0040, 1, 0, 0, 0, 0, 0};
        jobs[4] = '{4'b1111, 0, 0, 16'h0050, 0, 0, 0, 0, 0, 0};
        jobs[5] = '{4'b0100, 2, 2, 16'h0001, 0, 0, 0, 0, 0, 0};
        jobs[6] = '{4'b0010, 1, 1, 16'h0200, 0, 1, 1, 0, 0, 0};
        jobs[7] = '{4'b0001, 0, 0, 16'h0300, 0, 0, 0, 1, 1, 0};
        jobs[8] = '{4'b1000, 3, 3, 16'h7FF0, 0, 1, 0, 0, 0, 0};

        reset_n = 1'b0; cl_req = '0; cl_b_valid = '0; cl_b_data = '0; spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", cl_gnt, 4'b0000);
        chk("rst_in_en", sv_in_en, 1'b0);
        chk("rst_b_in", sv_b_in, 16'h0000);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_res_id", res_id, 2'd0);
        chk("rst_res_last", res_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_job(jobs[i]);
        chk("isolation_dead", dead_seen, 0);

        // Spurious solver flag while idle must not produce results or leave IDLE.
        rq.delete();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_idle_busy", busy, 1'b0);
        chk("spur_idle_res", rq.size(), 0);
        chk("spur_idle_gnt", cl_gnt, 4'b0000);

        // Reset during DRAIN after word 7; rr_ptr must return to 0 afterwards.
        jr = '{4'b0010, 1, 1, 16'h0100, 0, 0, 0, 0, 0, 7};
        run_job(jr);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_gnt", cl_gnt, 4'b0000);
        chk("mid_rst_in_en", sv_in_en, 1'b0);
        chk("mid_rst_b_in", sv_b_in, 16'h0000);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_res_data", res_data, 32'h0);
        chk("mid_rst_res_id", res_id, 2'd0);
        chk("mid_rst_res_last", res_last, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        jr = '{4'b0011, 0, 0, 16'h0400, 0, 0, 0, 0, 0, 0};
        run_job(jr);

        chk("grant_overlap", ovl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gsim_sched.md
Name: gsim_sched

Overview:
- Round-robin scheduler that time-shares one Gauss-Seidel solver core (16 signed 16-bit b inputs, 16 signed Q16.16 x outputs) among NUM_REQ clients.
- Grants one client at a time and forwards that client's 16 b words into the solver.
- Waits out the solver's fixed-iteration computation, then returns the 16-word x burst to the owning client, tagged with the client id.
- Sits between the client fabric and the solver; the only path into the solver.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8).
- ID_W, 2, client id width; must satisfy 2**ID_W >= NUM_REQ.
- NUM_VAR, 16, b words per job and x words per result.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cl_req  input  NUM_REQ  per-client job request, level.
- cl_gnt  output  NUM_REQ  one-hot grant, registered.
- cl_b_valid  input  NUM_REQ  per-client b word valid.
- cl_b_data  input  NUM_REQ*16  per-client b word; client k uses bits [16k+15:16k].
- sv_in_en  output  1  solver input enable, registered.
- sv_b_in  output  16  solver b word, registered.
- sv_out_valid  input  1  solver SEND-phase flag; x word appears on sv_x_out one cycle later.
- sv_x_out  input  32  solver x word (Q16.16).
- res_valid  output  1  result word valid, registered.
- res_data  output  32  result word.
- res_id  output  ID_W  owning client id.
- res_last  output  1  high with the 16th result word.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr 0, word counters 0.
- Reset asserted mid-job: the job is dropped with no partial result. The system ties the solver reset to ~reset_n, so both restart together.
- State IDLE:
  - If any cl_req bit is set, pick the first set bit searching upward from rr_ptr with wrap.
  - Register the grant, so cl_gnt is one-hot on the next cycle. Latch gid; go to LOAD.
  - With no requests, stay in IDLE.
- State LOAD:
  - Each cycle, sv_in_en <= cl_b_valid[gid] and sv_b_in <= cl_b_data[gid]. This is a 1-cycle forwarding latency.
  - Valid bits from non-granted clients are ignored.
  - ld_cnt increments on each accepted word. Gaps (valid low) are allowed.
  - When the NUM_VAR-th word is accepted, go to WAIT. Any further cl_b_valid[gid] that cycle or later is not forwarded (sv_in_en held 0).
- State WAIT:
  - Hold sv_in_en at 0.
  - On sv_out_valid=1, go to DRAIN. Set x_dly <= 1 so that sv_x_out is sampled on the following cycle.
  - No timeout: the solver computation length is fixed.
- State DRAIN:
  - Each cycle with x_dly=1: res_valid <= 1, res_data <= sv_x_out, res_id <= gid, res_last <= (rd_cnt == NUM_VAR-1). Then rd_cnt increments.
  - x_dly follows sv_out_valid delayed by one cycle.
  - After the word with res_last is issued: clear cl_gnt, set rr_ptr <= gid+1 (mod NUM_REQ), go to IDLE.
  - res_valid is a single-cycle pulse per word. There is no backpressure; clients must accept every word.
- sv_out_valid seen in IDLE or LOAD is a protocol violation. It is ignored: no res_valid, no state change.
- A client dropping cl_req while granted does not abort the job.
- Requests arriving during a job are held until IDLE and arbitrated then. The granting client re-requesting competes under normal round-robin.
- Minimum job-to-job gap: 1 IDLE cycle.
- Arithmetic: none on data. Words pass bit-exact. Counters are clog2(NUM_VAR)+1 bits and never wrap within a job.

Test Plan:
- Single job:
  - Stimulus: client 2 requests and drives b=1..16 on consecutive cycles. The solver model returns x_k = 0x00010000*k.
  - Required: cl_gnt=4'b0100 one cycle after cl_req. sv_in_en shows 16 pulses carrying 1..16, each one cycle after cl_b_valid. res_id=2 throughout, res_data=0x00010000..0x00100000 on 16 consecutive cycles, res_last on the 16th.
- Round-robin:
  - Stimulus: cl_req=4'b1111 held for 5 jobs.
  - Required: grant order 0,1,2,3,0. No grant overlap; busy drops for exactly 1 cycle between jobs.
- Gapped load:
  - Stimulus: client 1 drives valid on alternating cycles, plus a 17th valid after the 16th word.
  - Required: exactly 16 sv_in_en pulses, matching data order. The 17th word is not forwarded.
- Isolation:
  - Stimulus: client 0 granted while client 3 toggles cl_b_valid with data 0xDEAD.
  - Required: 0xDEAD never appears on sv_b_in.
- Spurious sv_out_valid:
  - Stimulus: pulse sv_out_valid in IDLE and in LOAD.
  - Required: no res_valid, and the state sequence is unchanged.
- Mid-job reset:
  - Stimulus: assert reset_n=0 during DRAIN after word 7.
  - Required: all outputs 0 immediately (asynchronous). After release, a new request from client 0 is granted, and its first result word has res_id=0.
